adder_status_stage: RTL and testbench

- Registered stage directly downstream of the or1420 combinational adder. It consumes the adder's result, carry, flag and operands.
- Holds the architectural status bits F (flag), CY (carry) and OV (overflow), and feeds F and CY back to the adder's flagIn/carryIn.
- Forwards results to writeback through a 2-entry skid buffer with valid/ready handshake; flush and stall supported.

---
 rtl/or1420_alu_pkg.sv | 40 ++++
 rtl/alu_skid_fifo.sv | 69 ++++++
 rtl/adder_status_stage.sv | 110 +++++++++++
 tb/tb_adder_status_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/or1420_alu_pkg.sv
// Shared types and constants for the or1420 adder status stage.
// Holds opcode encodings, skid entry layout, FIFO state type and overflow helper.
package or1420_alu_pkg;

    localparam logic [1:0] OPC_ADD  = 2'b00;
    localparam logic [1:0] OPC_ADDC = 2'b10;
    localparam logic [1:0] OPC_SUB  = 2'b11;

    localparam int SKID_DEPTH      = 2;
    localparam int ENTRY_IDX_WIDTH = 5;

    typedef struct packed {
        logic [31:0]                result;
        logic [ENTRY_IDX_WIDTH-1:0] idx;
        logic                       we;
    } skid_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    // Signed overflow from sign bits only. A subtract overflows when the
    // operands differ in sign and the result sign departs from A.
    function automatic logic ovf_detect(
        input logic [1:0] opc,
        input logic       a_msb,
        input logic       b_msb,
        input logic       r_msb
    );
        logic same_sign;
        same_sign = (a_msb == b_msb);
        if (opc == OPC_SUB)
            return ~same_sign & (r_msb != a_msb);
        else
            return same_sign & (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Generic 2-entry valid/ready FIFO with flush; state derived from occupancy.
// Ports: clock, reset, flush, push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data.
module alu_skid_fifo
    import or1420_alu_pkg::*;
#(
    parameter int WIDTH = 38
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    fifo_state_t      state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign push_ready = (state != FIFO_FULL);
    assign pop_valid  = (state != FIFO_EMPTY);
    assign pop_data   = head;
    assign push       = push_valid & push_ready;
    assign pop        = pop_ready & pop_valid;

    // Data registers are left untouched on pop-to-empty and flush so the
    // output stays stable while nothing is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FIFO_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= FIFO_EMPTY;
        end else begin
            unique case (state)
                FIFO_EMPTY: begin
                    if (push) begin
                        head  <= push_data;
                        state <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail  <= push_data;
                        state <= FIFO_FULL;
                    end else if (pop) begin
                        state <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= FIFO_ONE;
                    end
                end
                default: state <= FIFO_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/adder_status_stage.sv
// Registered stage after the or1420 adder: owns F/CY/OV, feeds F/CY back, skid-buffers results.
// Optional macro ADDER_OVERFLOW_EXCEPTION_EN enables overflowException and suppresses write-back on trap.
module adder_status_stage
    import or1420_alu_pkg::*;
#(
    parameter logic RESET_FLAG    = 1'b0,
    parameter logic RESET_CARRY   = 1'b0,
    parameter int   REG_IDX_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     flush,
    input  logic [1:0]               opcode,
    input  logic                     updateFlag,
    input  logic                     updateCarry,
    input  logic [31:0]              operandA,
    input  logic [31:0]              operandB,
    input  logic [31:0]              adderResult,
    input  logic                     adderCarry,
    input  logic                     adderFlag,
    input  logic [REG_IDX_WIDTH-1:0] rdIdx,
    input  logic                     rdWe,
    input  logic                     ovExcEnable,
    output logic                     flagIn,
    output logic                     carryIn,
    output logic                     overflowFlag,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outResult,
    output logic [REG_IDX_WIDTH-1:0] outIdx,
    output logic                     outWe,
    output logic                     overflowException
);

    typedef struct packed {
        logic [31:0]              result;
        logic [REG_IDX_WIDTH-1:0] idx;
        logic                     we;
    } entry_t;

    logic   accept;
    logic   ovf;
    logic   push_we;
    entry_t push_entry;
    entry_t head_entry;

    assign accept = inValid & inReady & ~flush;
    assign ovf    = ovf_detect(opcode, operandA[31],
                               operandB[31], adderResult[31]);

    // Only sign bits take part in overflow detection.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{operandA[30:0], operandB[30:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            flagIn       <= RESET_FLAG;
            carryIn      <= RESET_CARRY;
            overflowFlag <= 1'b0;
        end else if (accept) begin
            if (updateFlag)
                flagIn <= adderFlag;
            if (updateCarry) begin
                carryIn      <= adderCarry;
                overflowFlag <= ovf;
            end
        end
    end

`ifdef ADDER_OVERFLOW_EXCEPTION_EN
    logic ov_trap;
    assign ov_trap = updateCarry & ovf & ovExcEnable;
    assign push_we = rdWe & ~ov_trap;

    always_ff @(posedge clock) begin
        if (reset)
            overflowException <= 1'b0;
        else
            overflowException <= accept & ov_trap;
    end
`else
    logic unused_ov_exc_enable;
    assign unused_ov_exc_enable = ovExcEnable;
    assign push_we              = rdWe;
    assign overflowException    = 1'b0;
`endif

    assign push_entry = '{result: adderResult, idx: rdIdx, we: push_we};

    alu_skid_fifo #(
        .WIDTH($bits(entry_t))
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push_valid(accept),
        .push_ready(inReady),
        .push_data (push_entry),
        .pop_valid (outValid),
        .pop_ready (outReady),
        .pop_data  (head_entry)
    );

    assign outResult = head_entry.result;
    assign outIdx    = head_entry.idx;
    assign outWe     = head_entry.we;

endmodule

// File: tb/tb_adder_status_stage.sv
// Directed self-checking bench for adder_status_stage.
// Expected values are hand-computed per vector.
module tb_adder_status_stage;

`ifdef ADDER_OVERFLOW_EXCEPTION_EN
    localparam logic EXC_EN = 1'b1;
`else
    localparam logic EXC_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic        flush;
    logic [1:0]  opcode;
    logic        updateFlag;
    logic        updateCarry;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] adderResult;
    logic        adderCarry;
    logic        adderFlag;
    logic [4:0]  rdIdx;
    logic        rdWe;
    logic        ovExcEnable;
    logic        flagIn;
    logic        carryIn;
    logic        overflowFlag;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic [4:0]  outIdx;
    logic        outWe;
    logic        overflowException;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    adder_status_stage dut (
        .clock            (clock),
        .reset            (reset),
        .inValid          (inValid),
        .inReady          (inReady),
        .flush            (flush),
        .opcode           (opcode),
        .updateFlag       (updateFlag),
        .updateCarry      (updateCarry),
        .operandA         (operandA),
        .operandB         (operandB),
        .adderResult      (adderResult),
        .adderCarry       (adderCarry),
        .adderFlag        (adderFlag),
        .rdIdx            (rdIdx),
        .rdWe             (rdWe),
        .ovExcEnable      (ovExcEnable),
        .flagIn           (flagIn),
        .carryIn          (carryIn),
        .overflowFlag     (overflowFlag),
        .outValid         (outValid),
        .outReady         (outReady),
        .outResult        (outResult),
        .outIdx           (outIdx),
        .outWe            (outWe),
        .overflowException(overflowException)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] opc,
                         input logic uf, input logic uc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic c,
                         input logic f, input logic [4:0] idx);
        inValid     = v;
        opcode      = opc;
        updateFlag  = uf;
        updateCarry = uc;
        operandA    = a;
        operandB    = b;
        adderResult = r;
        adderCarry  = c;
        adderFlag   = f;
        rdIdx       = idx;
        rdWe        = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; outReady = 1'b1; ovExcEnable = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_flag",  flagIn, 0);
        check("rst_carry", carryIn, 0);
        check("rst_ov",    overflowFlag, 0);
        check("rst_valid", outValid, 0);
        check("rst_ready", inReady, 1);
        check("rst_res",   outResult, 0);
        check("rst_exc",   overflowException, 0);

        // add overflow
        ovExcEnable = 1'b1;
        drive(1, 2'b00, 0, 1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 5'd3);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        ovExcEnable = 1'b0;
        check("add_ov",    overflowFlag, 1);
        check("add_cy",    carryIn, 0);
        check("add_valid", outValid, 1);
        check("add_res",   outResult, 32'h80000000);
        check("add_idx",   outIdx, 3);
        check("add_we",    outWe, !EXC_EN);
        check("add_exc",   overflowException, EXC_EN);
        tick();
        check("add_exc_end", overflowException, 0);
        check("add_drain",   outValid, 0);

        // sub overflow, then sub without overflow
        drive(1, 2'b11, 0, 1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, 5'd4);
        tick();
        check("sub_ov",  overflowFlag, 1);
        check("sub_cy",  carryIn, 1);
        check("sub_res", outResult, 32'h7FFFFFFF);
        drive(1, 2'b11, 0, 1, 32'h5, 32'h3, 32'h2, 1, 0, 5'd5);
        tick();
        check("sub2_ov",    overflowFlag, 0);
        check("sub2_cy",    carryIn, 1);
        check("sub2_res",   outResult, 32'h2);
        check("sub2_valid", outValid, 1);

        // set-flag compare leaves CY/OV alone
        drive(1, 2'b00, 1, 0, 32'h1, 32'h1, 32'h0, 0, 1, 5'd0);
        tick();
        check("cmp_flag", flagIn, 1);
        check("cmp_cy",   carryIn, 1);
        check("cmp_ov",   overflowFlag, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("cmp_drain", outValid, 0);

        // backpressure
        outReady = 1'b0;
        drive(1, 2'b00, 0, 0, 0, 0, 32'h11, 0, 0, 5'd1);
        tick();
        check("bp_ready1", inReady, 1);
        drive(1, 2'b00, 0, 0, 0, 0, 32'h22, 0, 0, 5'd2);
        tick();
        check("bp_ready2", inReady, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 32'h33, 0, 0, 5'd3);
        tick();
        check("bp_ready3", inReady, 0);
        check("bp_hold",   outResult, 32'h11);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        outReady = 1'b1;
        check("bp_v1", outValid, 1);
        tick();
        check("bp_r2", outResult, 32'h22);
        check("bp_v2", outValid, 1);
        tick();
        check("bp_v3", outValid, 0);
        check("bp_stable", outResult, 32'h22);

        // flush with two buffered plus a valid input
        outReady = 1'b0;
        drive(1, 2'b00, 0, 0, 0, 0, 32'h44, 0, 0, 5'd4);
        tick();
        drive(1, 2'b00, 0, 0, 0, 0, 32'h55, 0, 0, 5'd5);
        tick();
        drive(1, 2'b00, 1, 1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fl_valid", outValid, 0);
        check("fl_ready", inReady, 1);
        check("fl_flag",  flagIn, 1);
        check("fl_cy",    carryIn, 1);
        check("fl_ov",    overflowFlag, 0);

        // reset mid-operation
        drive(1, 2'b00, 0, 0, 0, 0, 32'h66, 0, 0, 5'd6);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mid_valid", outValid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_valid", outValid, 0);
        check("mr_flag",  flagIn, 0);
        check("mr_cy",    carryIn, 0);
        check("mr_res",   outResult, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
